rgb_to_yuv_pipe: RTL
====================

# rgb_to_yuv_pipe

Parametrised, pipelined RGB→YUV colour-space converter: successor to the fixed 7-bit converter, with configurable channel/coefficient/output widths, runtime-reloadable 3×3 signed coefficient matrix, rounding, U/V offset and per-output FIFOs so Y, U and V sinks can stall independently. Sits between the pixel source and the three planar writers in the video datapath.

## Interface
Parameters:
- CH_W, 7, input bits per colour channel (unsigned)
- COEF_W, 8, signed coefficient width
- OUT_W, 8, output bits per Y/U/V sample
- SHIFT, 5, fractional bits of coefficients (right shift after accumulate, ≥1)
- FIFO_DEPTH, 4, entries per output FIFO (power of two, ≥4)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rgb_valid  in  1  pixel valid
- rgb_ready  out  1  pixel accepted when valid&ready
- rgb_data  in  3*CH_W  R=[CH_W-1:0], G=[2*CH_W-1:CH_W], B=[3*CH_W-1:2*CH_W]
- coeffs_valid  in  1  coefficient set valid
- coeffs_ready  out  1  coefficient set accepted when valid&ready
- coeffs_data  in  9*COEF_W  coef k at [k*COEF_W +: COEF_W], k=3*row+col; row 0/1/2=Y/U/V, col 0/1/2=R/G/B
- y_valid, u_valid, v_valid  out  1  output sample valid
- y_ready, u_ready, v_ready  in  1  output sample consumed
- y_data, u_data, v_data  out  OUT_W  output samples

## Operation
- FSM: IDLE (no coefficients; rgb_ready=0, coeffs_ready=1) → RUN on first coeff handshake. RUN: coeffs_ready=1 always; never returns to IDLE except by reset.
- Coefficient reload in RUN: new set applies to pixels accepted in cycles after the coeff handshake; a pixel accepted in the same cycle as a coeff handshake uses the old set. Pixels already in flight unaffected.
- Per row r: acc = Σ c[r][col]·pix[col], pixel zero-extended, signed, width COEF_W+CH_W+3 (no overflow possible).
- res = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic). Y: out = res; U,V: out = res + 2^(OUT_W-1).
- Final clamp to OUT_W bits per Configuration.
- Pipeline: S1 registers 9 products; S2 registers sum/round/offset/clamp; S2 writes all three FIFOs together.
- Flow control by credits: rgb_ready = RUN && for every FIFO, count + in-flight(S1,S2 valid) < FIFO_DEPTH. Computed from registered state only (no combinational path from y/u/v_ready to rgb_ready).
- Each FIFO pops independently; outputs are FIFO heads. FIFOs never overflow; write into a full FIFO is impossible by construction (verification assertion).
- Pointers wrap modulo FIFO_DEPTH; simultaneous push and pop on one FIFO leaves count unchanged.

## Timing
- Reset (rst low, async): FSM=IDLE, coefficients=0, pipeline valids=0, FIFOs empty. Outputs: rgb_ready=0, coeffs_ready=1, y/u/v_valid=0, y/u/v_data=0.
- Pixel accepted in cycle t → sample valid at all three outputs in cycle t+3 if FIFOs were empty (latency 3).
- Throughput 1 pixel/cycle when all sinks ready continuously.
- Pop in cycle t frees credit visible in rgb_ready at t+1.
- Reset mid-stream discards all in-flight pixels and loaded coefficients; coefficients must be reloaded.
- Output valid, once high, stays high with stable data until its ready.

## Configuration
- RGB2YUV_SAT_EN defined: out clamped to [0, 2^OUT_W−1] (negative→0, overflow→all-ones).
- Not defined: out = low OUT_W bits of result (wrap), no clamp logic.

## Test plan
- Reset, no coeffs: rgb_valid=1 → rgb_ready stays 0, outputs invalid; coeffs_ready=1.
- Coeffs Y=(19,38,7), U=(−11,−21,32), V=(32,−27,−5); pixel (127,127,127) → Y=254, U=128, V=128 at t+3.
- Same coeffs, pixel (127,0,0) → Y=75, U=84, V=255.
- Coeffs Y=(127,127,127), pixel (127,127,127) → Y=255 with RGB2YUV_SAT_EN, Y=232 without.
- Hold u_ready=0, y/v ready=1, stream pixels → exactly FIFO_DEPTH accepted, rgb_ready=0, Y/V drain; release u_ready → U emits all in order, stream resumes with no loss/duplication.
- Reload coeffs in same cycle as pixel handshake → that pixel uses old set, next pixel new set; assert rst mid-stream → all valids 0 immediately, rgb_ready=0 until reload.

Source files
------------

// File: rtl/rgb_to_yuv_pipe.sv
// rgb_to_yuv_pipe: pipelined RGB -> YUV converter with a reloadable signed
// 3x3 coefficient matrix, round-half-up, U/V mid-scale offset and one small
// FIFO per output plane so the Y, U and V sinks can stall independently.
//
// Build option: define RGB2YUV_SAT_EN to clamp outputs to [0, 2^OUT_W-1];
// otherwise the low OUT_W bits of the result are kept (wrap-around).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no coefficient set loaded yet; pixels refused
// ST_RUN  | coefficients valid; pixels accepted while every FIFO has credit
module rgb_to_yuv_pipe #(
    parameter int CH_W       = 7,
    parameter int COEF_W     = 8,
    parameter int OUT_W      = 8,
    parameter int SHIFT      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rgb_valid,
    output logic                  rgb_ready,
    input  logic [3*CH_W-1:0]     rgb_data,
    input  logic                  coeffs_valid,
    output logic                  coeffs_ready,
    input  logic [9*COEF_W-1:0]   coeffs_data,
    output logic                  y_valid,
    output logic                  u_valid,
    output logic                  v_valid,
    input  logic                  y_ready,
    input  logic                  u_ready,
    input  logic                  v_ready,
    output logic [OUT_W-1:0]      y_data,
    output logic [OUT_W-1:0]      u_data,
    output logic [OUT_W-1:0]      v_data
);

    localparam int ACC_W = COEF_W + CH_W + 3;
    localparam int RES_W = ACC_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic signed [ACC_W-1:0] RND    = ACC_W'(2 ** (SHIFT - 1));
    localparam logic signed [RES_W-1:0] UV_OFF = RES_W'(2 ** (OUT_W - 1));
`ifdef RGB2YUV_SAT_EN
    localparam logic signed [RES_W-1:0] OUT_MAX = RES_W'(2 ** OUT_W - 1);
`endif

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [9*COEF_W-1:0]       coef_q;
    logic                      pix_acc;
    logic                      credit_ok;
    logic [CNT_W:0]            fill [3];

    logic signed [ACC_W-1:0]   prod_d [9];
    logic signed [ACC_W-1:0]   prod_q [9];
    logic                      s1_valid_q;

    logic signed [ACC_W-1:0]   acc_s2 [3];
    logic signed [ACC_W-1:0]   res_s2 [3];
    logic signed [RES_W-1:0]   val_s2 [3];
    logic [OUT_W-1:0]          out_d  [3];
    logic [OUT_W-1:0]          s2_data_q [3];
    logic                      s2_valid_q;

    logic [OUT_W-1:0]          mem_q [3][FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q [3];
    logic [PTR_W-1:0]          rd_ptr_q [3];
    logic [CNT_W-1:0]          cnt_q [3];
    logic                      sink_ready [3];
    logic                      pop [3];

    // Final clamp (saturating build) or plain truncation (wrapping build).
    function automatic logic [OUT_W-1:0] fit(input logic signed [RES_W-1:0] v);
`ifdef RGB2YUV_SAT_EN
        if (v < 0) return '0;
        if (v > OUT_MAX) return '1;
        return v[OUT_W-1:0];
`else
        return v[OUT_W-1:0];
`endif
    endfunction

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state and handshake outputs; credit uses registered state only.
    always_comb begin
        state_d      = state_q;
        coeffs_ready = 1'b1;
        credit_ok    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fill[i] = (CNT_W + 1)'(cnt_q[i]) + (CNT_W + 1)'(s1_valid_q)
                    + (CNT_W + 1)'(s2_valid_q);
            if (fill[i] >= (CNT_W + 1)'(FIFO_DEPTH)) credit_ok = 1'b0;
        end
        rgb_ready = (state_q == ST_RUN) && credit_ok;
        if (state_q == ST_IDLE && coeffs_valid) state_d = ST_RUN;
        pix_acc = rgb_valid && rgb_ready;
    end

    // Coefficient store; a pixel accepted in the load cycle still sees the old set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              coef_q <= '0;
        else if (coeffs_valid) coef_q <= coeffs_data;
    end

    // Stage 1 operands: signed coefficient times zero-extended channel.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            prod_d[k] = ACC_W'($signed(coef_q[k*COEF_W +: COEF_W]))
                      * ACC_W'($signed({1'b0, rgb_data[(k % 3)*CH_W +: CH_W]}));
        end
    end

    // Stage 1 register: nine products.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            prod_q     <= '{default: '0};
        end else begin
            s1_valid_q <= pix_acc;
            if (pix_acc) prod_q <= prod_d;
        end
    end

    // Stage 2 arithmetic: row sums, round-half-up, shift, U/V offset, clamp.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            acc_s2[r] = prod_q[3*r] + prod_q[3*r+1] + prod_q[3*r+2];
            res_s2[r] = (acc_s2[r] + RND) >>> SHIFT;
            val_s2[r] = RES_W'(res_s2[r]) + ((r != 0) ? UV_OFF : '0);
            out_d[r]  = fit(val_s2[r]);
        end
    end

    // Stage 2 register: finished Y/U/V samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '{default: '0};
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) s2_data_q <= out_d;
        end
    end

    // Per-plane pop requests.
    always_comb begin
        sink_ready[0] = y_ready;
        sink_ready[1] = u_ready;
        sink_ready[2] = v_ready;
        for (int i = 0; i < 3; i++) pop[i] = sink_ready[i] && (cnt_q[i] != '0);
    end

    // FIFO storage; contents need no reset because outputs are gated by count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (s2_valid_q) mem_q[i][wr_ptr_q[i]] <= s2_data_q[i];
        end
    end

    // FIFO pointers and occupancy; all three planes are pushed together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            cnt_q    <= '{default: '0};
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s2_valid_q) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                if (pop[i])     rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                if (s2_valid_q && !pop[i])      cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                else if (!s2_valid_q && pop[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
        end
    end

    assign y_valid = (cnt_q[0] != '0);
    assign u_valid = (cnt_q[1] != '0);
    assign v_valid = (cnt_q[2] != '0);
    assign y_data  = y_valid ? mem_q[0][rd_ptr_q[0]] : '0;
    assign u_data  = u_valid ? mem_q[1][rd_ptr_q[1]] : '0;
    assign v_data  = v_valid ? mem_q[2][rd_ptr_q[2]] : '0;

    // Credit accounting must make a push into a full FIFO impossible.
    for (genvar gi = 0; gi < 3; gi++) begin : g_no_overflow
        assert property (@(posedge clk) disable iff (!rst)
                         !(s2_valid_q && cnt_q[gi] == CNT_W'(FIFO_DEPTH)));
    end

endmodule
